savestate_sequencer: RTL

- Sits between the savestate UI front-end and the savestate engine.
- Arbitrates three request sources onto the engine's single-op start/done interface: user save/load pulses, periodic rewind captures, and rewind restores.
- Owns the rewind ring index and count, pauses the core for the duration of each op, and issues the OSD info codes for completed and failed ops.

---
 rtl/savestate_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/savestate_sequencer.sv
// savestate_sequencer: arbitrates user save/load requests, periodic rewind
// captures and rewind restores onto the single-op savestate engine. It owns
// the rewind ring head/count, pauses the core during each op and emits OSD
// info codes when an op completes or times out.
module savestate_sequencer #(
    parameter int REWIND_SLOTS = 8,
    parameter int CAPTURE_BITS = 24,
    parameter int STEP_BITS    = 22,
    parameter int TIMEOUT_BITS = 26
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_allow_ss,
    input  logic       i_ui_save,
    input  logic       i_ui_load,
    input  logic [1:0] i_ui_slot,
    input  logic       i_rewind_enable,
    input  logic       i_rewind_hold,
    output logic       o_eng_start,
    output logic       o_eng_load,
    output logic       o_eng_rewind,
    output logic [3:0] o_eng_index,
    input  logic       i_eng_done,
    output logic       o_core_pause,
    output logic       o_busy,
    output logic [4:0] o_rewind_count,
    output logic       o_info_req,
    output logic [7:0] o_info_code
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FINISH} state_t;

    localparam logic [3:0] IDX_MASK  = 4'(REWIND_SLOTS - 1);
    localparam logic [4:0] RING_FULL = 5'(REWIND_SLOTS);

    state_t                  r_state;
    logic                    r_save_pend;
    logic                    r_load_pend;
    logic                    r_cap_pend;
    logic                    r_rst_pend;
    logic [1:0]              r_slot;
    logic [3:0]              r_head;
    logic [CAPTURE_BITS-1:0] r_cap_tmr;
    logic [STEP_BITS-1:0]    r_rst_tmr;
    logic [TIMEOUT_BITS-1:0] r_wd;

    logic                    w_ui_pulse;
    logic                    w_load_any;
    logic                    w_save_any;
    logic [1:0]              w_slot;
    logic                    w_cap_tick;
    logic                    w_cap_wrap;
    logic                    w_rst_tick;
    logic                    w_rst_wrap;
    logic                    w_grant;
    logic [3:0]              w_head_m1;
    logic [3:0]              w_head_p1;
    logic [TIMEOUT_BITS-1:0] w_wd_inc;

    // A pulse arriving this cycle is already eligible for arbitration, so a
    // request in IDLE starts the engine on the very next cycle.
    assign w_ui_pulse = i_ui_save | i_ui_load;
    assign w_load_any = r_load_pend | i_ui_load;
    assign w_save_any = r_save_pend | i_ui_save;
    assign w_slot     = w_ui_pulse ? i_ui_slot : r_slot;

    assign w_cap_tick = i_rewind_enable & i_allow_ss & ~i_rewind_hold & (r_state == S_IDLE);
    assign w_cap_wrap = w_cap_tick & (r_cap_tmr == {CAPTURE_BITS{1'b1}});
    assign w_rst_tick = i_rewind_enable & i_rewind_hold;
    assign w_rst_wrap = w_rst_tick & (r_rst_tmr == {STEP_BITS{1'b1}}) & (o_rewind_count != 5'd0);

    assign w_grant   = (r_state == S_IDLE) & i_allow_ss &
                       (w_load_any | w_save_any | r_rst_pend | r_cap_pend);
    assign w_head_m1 = (r_head - 4'd1) & IDX_MASK;
    assign w_head_p1 = (r_head + 4'd1) & IDX_MASK;
    assign w_wd_inc  = r_wd + 1'b1;

    // Capture interval timer: runs only while idle and allowed, zero when rewind is off
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_rewind_enable) begin
            r_cap_tmr <= '0;
        end else if (w_cap_tick) begin
            r_cap_tmr <= r_cap_tmr + 1'b1;
        end
    end

    // Restore step timer: runs while rewind is held, restarts on release
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_rewind_hold) begin
            r_rst_tmr <= '0;
        end else if (w_rst_tick) begin
            r_rst_tmr <= r_rst_tmr + 1'b1;
        end
    end

    // Request latching, arbitration, op sequencing, ring bookkeeping and OSD info
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_save_pend    <= 1'b0;
            r_load_pend    <= 1'b0;
            r_cap_pend     <= 1'b0;
            r_rst_pend     <= 1'b0;
            r_slot         <= 2'd0;
            r_head         <= 4'd0;
            r_wd           <= '0;
            o_eng_start    <= 1'b0;
            o_eng_load     <= 1'b0;
            o_eng_rewind   <= 1'b0;
            o_eng_index    <= 4'd0;
            o_core_pause   <= 1'b0;
            o_busy         <= 1'b0;
            o_rewind_count <= 5'd0;
            o_info_req     <= 1'b0;
            o_info_code    <= 8'd0;
        end else begin
            o_info_req <= 1'b0;

            // Requests are captured in every state; the grant below clears what it serves.
            if (w_ui_pulse)      r_slot      <= i_ui_slot;
            if (i_ui_save)       r_save_pend <= 1'b1;
            if (i_ui_load)       r_load_pend <= 1'b1;
            if (w_cap_wrap)      r_cap_pend  <= 1'b1;
            if (w_rst_wrap)      r_rst_pend  <= 1'b1;
            if (!i_rewind_enable) begin
                r_cap_pend <= 1'b0;
                r_rst_pend <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state      <= S_START;
                        o_eng_start  <= 1'b1;
                        o_core_pause <= 1'b1;
                        o_busy       <= 1'b1;
                        if (w_load_any) begin
                            o_eng_load   <= 1'b1;
                            o_eng_rewind <= 1'b0;
                            o_eng_index  <= {2'b00, w_slot};
                            r_load_pend  <= 1'b0;
                        end else if (w_save_any) begin
                            o_eng_load   <= 1'b0;
                            o_eng_rewind <= 1'b0;
                            o_eng_index  <= {2'b00, w_slot};
                            r_save_pend  <= 1'b0;
                        end else if (r_rst_pend) begin
                            // A restore supersedes any capture that was waiting.
                            o_eng_load   <= 1'b1;
                            o_eng_rewind <= 1'b1;
                            o_eng_index  <= w_head_m1;
                            r_rst_pend   <= 1'b0;
                            r_cap_pend   <= 1'b0;
                        end else begin
                            o_eng_load   <= 1'b0;
                            o_eng_rewind <= 1'b1;
                            o_eng_index  <= r_head;
                            r_cap_pend   <= 1'b0;
                        end
                    end
                end
                S_START: begin
                    o_eng_start <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_eng_done || w_wd_inc[TIMEOUT_BITS-1]) begin
                        r_state      <= S_FINISH;
                        o_core_pause <= 1'b0;
                        r_wd         <= '0;
                        if (!i_eng_done) begin
                            o_info_req  <= 1'b1;
                            o_info_code <= 8'd15;
                        end else if (!o_eng_rewind) begin
                            o_info_req  <= 1'b1;
                            o_info_code <= 8'd6 + {5'd0, o_eng_index[1:0], o_eng_load};
                        end else if (o_eng_load) begin
                            o_info_req     <= 1'b1;
                            o_info_code    <= 8'd14;
                            r_head         <= w_head_m1;
                            o_rewind_count <= o_rewind_count - 5'd1;
                        end else begin
                            // At a full ring the head still advances, overwriting the oldest entry.
                            r_head <= w_head_p1;
                            if (o_rewind_count != RING_FULL) begin
                                o_rewind_count <= o_rewind_count + 5'd1;
                            end
                        end
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    o_busy       <= 1'b0;
                    o_eng_load   <= 1'b0;
                    o_eng_rewind <= 1'b0;
                    o_eng_index  <= 4'd0;
                end
            endcase
        end
    end

endmodule
